// File: rtl/counter4b_checker_pkg.sv
// Shared definitions for the 4-bit counter and its checker:
// logic levels, MODO encodings, checker state codes and the run condition.
package counter4b_checker_pkg;

   localparam logic ALTO = 1'b1;
   localparam logic BAJO = 1'b0;

   localparam logic [1:0] MODO_UP   = 2'b00;
   localparam logic [1:0] MODO_DN1  = 2'b01;
   localparam logic [1:0] MODO_DN3  = 2'b10;
   localparam logic [1:0] MODO_LOAD = 2'b11;

   localparam logic [1:0] ST_UNSYNC = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_HALT   = 2'd2;

   function automatic logic cnt_run(input logic enable, input logic reset);
      return (enable == ALTO) && (reset == BAJO);
   endfunction

endpackage

// File: rtl/counter4b_model.sv
// Combinational next-state model of the 4-bit counter: next Q, RCO and LOAD
// for the given stimulus and current Q.
module counter4b_model
   import counter4b_checker_pkg::*;
(
   input  logic       enable,
   input  logic       reset,
   input  logic [1:0] modo,
   input  logic [3:0] d,
   input  logic [3:0] q,
   output logic [3:0] q_nx,
   output logic       rco_nx,
   output logic       load_nx
);

   logic [4:0] sum;

   // RCO is the carry/borrow out of the 5-bit result
   always_comb begin
      sum     = '0;
      load_nx = BAJO;
      if (cnt_run(enable, reset)) begin
         case (modo)
            MODO_UP:   sum = {1'b0, q} + 5'd1;
            MODO_DN1:  sum = {1'b0, q} - 5'd1;
            MODO_DN3:  sum = {1'b0, q} - 5'd3;
            MODO_LOAD: begin
               sum     = {1'b0, d};
               load_nx = ALTO;
            end
            default:   sum = '0;
         endcase
      end
   end

   assign q_nx   = sum[3:0];
   assign rco_nx = sum[4];

endmodule

// File: rtl/counter4b_checker.sv
// Online checker for the 4-bit counter: tracks a reference model, flags
// mismatches, and keeps saturating error and RCO event counts.
module counter4b_checker
   import counter4b_checker_pkg::*;
#(
   parameter int ERR_W = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CNT_ENABLE,
   input  logic             CNT_RESET,
   input  logic [1:0]       CNT_MODO,
   input  logic [3:0]       CNT_D,
   input  logic [3:0]       CNT_Q,
   input  logic             CNT_RCO,
   input  logic             CNT_LOAD,
   input  logic             STOP_ON_ERR,
   input  logic             CLR,
   output logic             SYNCED,
   output logic             MISMATCH,
   output logic             ERROR,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic [ERR_W-1:0] RCO_CNT
);

   localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

   logic [1:0]       state;
   logic [3:0]       exp_q;
   logic             exp_rco;
   logic             exp_load;
   logic             mismatch_r;
   logic             error_r;
   logic [ERR_W-1:0] err_cnt;
   logic [ERR_W-1:0] rco_cnt;

   logic             diff;
   logic [3:0]       base_q;
   logic [3:0]       q_nx;
   logic             rco_nx;
   logic             load_nx;

   assign diff = (state == ST_CHECK) &&
                 ({CNT_RCO, CNT_LOAD, CNT_Q} != {exp_rco, exp_load, exp_q});

   // Reseed from the observed Q so a single fault yields a single error
   assign base_q = (diff && !STOP_ON_ERR) ? CNT_Q : exp_q;

   counter4b_model u_model (
      .enable  (CNT_ENABLE),
      .reset   (CNT_RESET),
      .modo    (CNT_MODO),
      .d       (CNT_D),
      .q       (base_q),
      .q_nx    (q_nx),
      .rco_nx  (rco_nx),
      .load_nx (load_nx)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= ST_UNSYNC;
         exp_q      <= '0;
         exp_rco    <= 1'b0;
         exp_load   <= 1'b0;
         mismatch_r <= 1'b0;
         error_r    <= 1'b0;
         err_cnt    <= '0;
         rco_cnt    <= '0;
      end else if (CLR) begin
         state      <= ST_UNSYNC;
         exp_q      <= '0;
         exp_rco    <= 1'b0;
         exp_load   <= 1'b0;
         mismatch_r <= 1'b0;
         error_r    <= 1'b0;
         err_cnt    <= '0;
         rco_cnt    <= '0;
      end else begin
         mismatch_r <= 1'b0;
         case (state)
            ST_UNSYNC: begin
               if (!cnt_run(CNT_ENABLE, CNT_RESET) || (CNT_MODO == MODO_LOAD)) begin
                  state    <= ST_CHECK;
                  exp_q    <= q_nx;
                  exp_rco  <= rco_nx;
                  exp_load <= load_nx;
               end
            end
            ST_CHECK: begin
               mismatch_r <= diff;
               if (diff) begin
                  error_r <= 1'b1;
                  if (err_cnt != '1)
                     err_cnt <= err_cnt + CNT_ONE;
               end
               if (diff && STOP_ON_ERR) begin
                  state <= ST_HALT;
               end else begin
                  exp_q    <= q_nx;
                  exp_rco  <= rco_nx;
                  exp_load <= load_nx;
                  if (rco_nx && (rco_cnt != '1))
                     rco_cnt <= rco_cnt + CNT_ONE;
               end
            end
            ST_HALT: ;
            default: state <= ST_UNSYNC;
         endcase
      end
   end

   assign SYNCED   = (state == ST_CHECK);
   assign MISMATCH = mismatch_r;
   assign ERROR    = error_r;
   assign ERR_CNT  = err_cnt;
   assign RCO_CNT  = rco_cnt;

endmodule

// File: tb/tb_counter4b_checker.sv
// Directed bench: a behavioural 4-bit counter drives the checker, with
// injected state glitches and a stuck LOAD output as faults.
module tb_counter4b_checker;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       CNT_ENABLE, CNT_RESET, STOP_ON_ERR, CLR;
   logic [1:0] CNT_MODO;
   logic [3:0] CNT_D;
   logic [3:0] CNT_Q;
   logic       CNT_RCO, CNT_LOAD;
   logic       SYNCED, MISMATCH, ERROR;
   logic [7:0] ERR_CNT, RCO_CNT;

   logic [3:0] ctr_q    = 4'd0;
   logic       ctr_rco  = 1'b0;
   logic       ctr_load = 1'b0;
   logic       glitch     = 1'b0;
   logic [3:0] glitch_val = 4'd0;
   logic       load_stuck = 1'b0;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   counter4b_checker #(.ERR_W(8)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .CNT_ENABLE  (CNT_ENABLE),
      .CNT_RESET   (CNT_RESET),
      .CNT_MODO    (CNT_MODO),
      .CNT_D       (CNT_D),
      .CNT_Q       (CNT_Q),
      .CNT_RCO     (CNT_RCO),
      .CNT_LOAD    (CNT_LOAD),
      .STOP_ON_ERR (STOP_ON_ERR),
      .CLR         (CLR),
      .SYNCED      (SYNCED),
      .MISMATCH    (MISMATCH),
      .ERROR       (ERROR),
      .ERR_CNT     (ERR_CNT),
      .RCO_CNT     (RCO_CNT)
   );

   // Counter under observation; a glitch overwrites its state for one edge
   always @(posedge CLK) begin
      if (glitch) begin
         ctr_q    <= glitch_val;
         ctr_rco  <= 1'b0;
         ctr_load <= 1'b0;
      end else if (CNT_ENABLE && !CNT_RESET) begin
         case (CNT_MODO)
            2'b00:   {ctr_rco, ctr_q} <= {1'b0, ctr_q} + 5'd1;
            2'b01:   {ctr_rco, ctr_q} <= {1'b0, ctr_q} - 5'd1;
            2'b10:   {ctr_rco, ctr_q} <= {1'b0, ctr_q} - 5'd3;
            default: {ctr_rco, ctr_q} <= {1'b0, CNT_D};
         endcase
         ctr_load <= (CNT_MODO == 2'b11);
      end else begin
         ctr_q    <= 4'd0;
         ctr_rco  <= 1'b0;
         ctr_load <= 1'b0;
      end
   end

   assign CNT_Q    = ctr_q;
   assign CNT_RCO  = ctr_rco;
   assign CNT_LOAD = ctr_load | load_stuck;

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      RESET = 1'b0; CNT_ENABLE = 1'b0; CNT_RESET = 1'b0; CNT_MODO = 2'b00;
      CNT_D = 4'd0; STOP_ON_ERR = 1'b0; CLR = 1'b0;
      #1;
      chk("rst_synced",   32'(SYNCED),   0);
      chk("rst_mismatch", 32'(MISMATCH), 0);
      chk("rst_error",    32'(ERROR),    0);
      chk("rst_err_cnt",  32'(ERR_CNT),  0);
      chk("rst_rco_cnt",  32'(RCO_CNT),  0);
      @(negedge CLK);
      RESET = 1'b1;

      // Counter reset then count up 20 cycles: one wrap
      CNT_ENABLE = 1'b1; CNT_RESET = 1'b1;
      tick(1);
      chk("sync_after_cnt_reset", 32'(SYNCED), 1);
      CNT_RESET = 1'b0;
      tick(15);
      chk("rco_cnt_at_q15", 32'(RCO_CNT), 0);
      tick(5);
      chk("up20_synced",  32'(SYNCED),  1);
      chk("up20_error",   32'(ERROR),   0);
      chk("up20_rco_cnt", 32'(RCO_CNT), 1);
      chk("up20_err_cnt", 32'(ERR_CNT), 0);

      // Load 2 then count down by 3: 2 -> 15 (borrow) -> 12 -> 9
      CNT_MODO = 2'b11; CNT_D = 4'd2;
      tick(1);
      CNT_MODO = 2'b10;
      tick(1);
      chk("dn3_borrow_rco_cnt", 32'(RCO_CNT), 2);
      tick(2);
      chk("dn3_rco_cnt",  32'(RCO_CNT),  2);
      chk("dn3_err_cnt",  32'(ERR_CNT),  0);
      chk("dn3_mismatch", 32'(MISMATCH), 0);

      // Single glitch to 5 where 4 is expected, continue on error
      CNT_MODO = 2'b11; CNT_D = 4'd3;
      tick(1);
      CNT_MODO = 2'b00; glitch = 1'b1; glitch_val = 4'd5;
      tick(1);
      glitch = 1'b0;
      chk("glitch_pre_mismatch", 32'(MISMATCH), 0);
      tick(1);
      chk("glitch_mismatch", 32'(MISMATCH), 1);
      chk("glitch_err_cnt",  32'(ERR_CNT),  1);
      chk("glitch_error",    32'(ERROR),    1);
      chk("glitch_synced",   32'(SYNCED),   1);
      tick(1);
      chk("glitch_pulse_end", 32'(MISMATCH), 0);
      chk("glitch_resumed",   32'(SYNCED),   1);
      tick(3);
      chk("glitch_err_cnt_hold", 32'(ERR_CNT), 1);

      // Clear, resync on a load, same glitch with stop-on-error
      CLR = 1'b1; CNT_MODO = 2'b11; CNT_D = 4'd3;
      tick(1);
      CLR = 1'b0;
      chk("clr_synced",  32'(SYNCED),  0);
      chk("clr_error",   32'(ERROR),   0);
      chk("clr_err_cnt", 32'(ERR_CNT), 0);
      chk("clr_rco_cnt", 32'(RCO_CNT), 0);
      tick(1);
      chk("load_resync", 32'(SYNCED), 1);
      CNT_MODO = 2'b00; STOP_ON_ERR = 1'b1; glitch = 1'b1; glitch_val = 4'd5;
      tick(1);
      glitch = 1'b0;
      chk("stop_pre_synced", 32'(SYNCED), 1);
      tick(1);
      chk("halt_synced",   32'(SYNCED),   0);
      chk("halt_mismatch", 32'(MISMATCH), 1);
      chk("halt_err_cnt",  32'(ERR_CNT),  1);
      chk("halt_error",    32'(ERROR),    1);
      tick(15);
      chk("halt_frozen_err", 32'(ERR_CNT),  1);
      chk("halt_frozen_rco", 32'(RCO_CNT),  0);
      chk("halt_no_pulse",   32'(MISMATCH), 0);
      chk("halt_stays",      32'(SYNCED),   0);
      CLR = 1'b1;
      tick(1);
      CLR = 1'b0;
      chk("halt_clr_error",   32'(ERROR),   0);
      chk("halt_clr_err_cnt", 32'(ERR_CNT), 0);
      chk("halt_clr_synced",  32'(SYNCED),  0);

      // Persistent stuck LOAD for 300 cycles: error count saturates
      STOP_ON_ERR = 1'b0; CNT_ENABLE = 1'b0;
      tick(1);
      chk("idle_resync", 32'(SYNCED), 1);
      CNT_ENABLE = 1'b1; load_stuck = 1'b1;
      tick(254);
      chk("sat_254",          32'(ERR_CNT),  254);
      chk("sat_mismatch_on",  32'(MISMATCH), 1);
      tick(1);
      chk("sat_255", 32'(ERR_CNT), 255);
      tick(45);
      chk("sat_hold",    32'(ERR_CNT), 255);
      chk("sat_error",   32'(ERROR),   1);
      chk("sat_rco_cnt", 32'(RCO_CNT), 18);
      load_stuck = 1'b0;
      tick(1);
      chk("sat_release_mismatch", 32'(MISMATCH), 0);
      chk("sat_release_err",      32'(ERR_CNT),  255);

      // Asynchronous reset mid-count, then resync on an idle cycle
      tick(2);
      #2 RESET = 1'b0;
      #1;
      chk("arst_synced",  32'(SYNCED),  0);
      chk("arst_error",   32'(ERROR),   0);
      chk("arst_err_cnt", 32'(ERR_CNT), 0);
      chk("arst_rco_cnt", 32'(RCO_CNT), 0);
      #1 RESET = 1'b1;
      @(negedge CLK);
      chk("arst_unsync_while_running", 32'(SYNCED), 0);
      CNT_ENABLE = 1'b0;
      tick(1);
      chk("arst_resync", 32'(SYNCED), 1);
      CNT_ENABLE = 1'b1;
      tick(10);
      chk("arst_run_err_cnt", 32'(ERR_CNT), 0);
      chk("arst_run_error",   32'(ERROR),   0);
      chk("arst_run_synced",  32'(SYNCED),  1);
      chk("arst_run_rco_cnt", 32'(RCO_CNT), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
